// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_5  = 2'd0,
    COIN_10 = 2'd1,
    COIN_25 = 2'd2,
    COIN_50 = 2'd3
  } coin_e;

  localparam int unsigned COIN_VAL [4] = '{5, 10, 25, 50};

  // Widest price vector price_of accepts; callers zero-extend into it.
  localparam int unsigned PRICE_VEC_W = 256;

  function automatic int unsigned coin_val(input coin_e c);
    return COIN_VAL[c];
  endfunction

  // Extract the cw-bit price of product idx from a packed price vector.
  function automatic int unsigned price_of(input logic [PRICE_VEC_W-1:0] prices,
                                           input int unsigned idx,
                                           input int unsigned cw);
    int unsigned mask;
    mask = (32'd1 << cw) - 32'd1;
    return 32'(prices >> (idx * cw)) & mask;
  endfunction

endpackage

// File: rtl/vend_inact_timer.sv
// Inactivity counter: counts while enabled, restarts on clear, saturates at expiry.
module vend_inact_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (!expired_c) begin
      cnt <= cnt + TW'(1);
    end
  end

  // Expiry is flagged during the last idle cycle so the refund lands TIMEOUT_CYC cycles later.
  assign expired_c = (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product coin vending controller with change/refund handshake.
// Optional inactivity auto-refund enabled by defining VEND_INACT_TIMEOUT_EN.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned          CW          = 8,
  parameter int unsigned          N_PROD      = 4,
  parameter logic [N_PROD*CW-1:0] PRICES      = {8'd45, 8'd20, 8'd25, 8'd30},
  parameter int unsigned          TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      start_n,
  input  logic                      coin_valid,
  input  logic [1:0]                coin_type,
  input  logic [$clog2(N_PROD)-1:0] sel,
  input  logic                      buy,
  input  logic                      cancel,
  output logic [CW-1:0]             credit,
  output logic                      dispense,
  output logic [$clog2(N_PROD)-1:0] dispense_id,
  output logic                      coin_reject,
  output logic                      change_valid,
  output logic [CW-1:0]             change_amt,
  input  logic                      change_ready,
  output logic                      busy
);

  state_e        state;
  state_e        state_n;
  logic [CW-1:0] credit_n;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] price;
  logic          reject_n;
  logic          buy_acc;
  logic          timeout_c;

`ifdef VEND_INACT_TIMEOUT_EN
  logic tmr_en;

  assign tmr_en = (state == ST_CREDIT) && (state_n == ST_CREDIT);

  vend_inact_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_inact_timer (
    .clk       (clk),
    .rst_n     (start_n),
    .clr       (coin_valid && !coin_sum[CW]),
    .en        (tmr_en),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next state / credit; cancel beats buy beats coin, a carry out of coin_sum means overflow.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    reject_n = 1'b0;
    buy_acc  = 1'b0;
    coin_sum = {1'b0, credit} + (CW+1)'(coin_val(coin_e'(coin_type)));
    price    = CW'(price_of(PRICE_VEC_W'(PRICES), 32'(sel), CW));
    case (state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (credit != '0)) begin
          state_n  = ST_CHANGE;
          reject_n = coin_valid;
        end else if (buy && (credit >= price)) begin
          state_n  = ST_VEND;
          credit_n = credit - price;
          buy_acc  = 1'b1;
          reject_n = coin_valid;
        end else if (coin_valid && !coin_sum[CW]) begin
          state_n  = ST_CREDIT;
          credit_n = coin_sum[CW-1:0];
        end else if (timeout_c && (state == ST_CREDIT)) begin
          state_n  = ST_CHANGE;
          reject_n = coin_valid;
        end else begin
          reject_n = coin_valid;
        end
      end
      ST_VEND: begin
        reject_n = coin_valid;
        state_n  = (credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        reject_n = coin_valid;
        if (change_valid && change_ready) begin
          credit_n = '0;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next-state decision.
  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      dispense     <= 1'b0;
      dispense_id  <= '0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      dispense     <= buy_acc;
      dispense_id  <= buy_acc ? sel : '0;
      coin_reject  <= reject_n;
      change_valid <= (state_n == ST_CHANGE);
      change_amt   <= (state_n == ST_CHANGE) ? credit_n : '0;
      busy         <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus feeds a credit/phase model, a monitor pops and compares.
module tb_vend_ctrl_multi;

  localparam int TMO = 20;
  localparam logic [31:0] PRICES = {8'd45, 8'd20, 8'd25, 8'd30};
  localparam int PRICE_TAB [4] = '{30, 25, 20, 45};
  localparam int COIN_TAB  [4] = '{5, 10, 25, 50};

  logic       clk = 1'b0;
  logic       start_n = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic [1:0] sel = 2'd0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b0;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       coin_reject;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       busy;

  vend_ctrl_multi #(
    .CW          (8),
    .N_PROD      (4),
    .PRICES      (PRICES),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .start_n      (start_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel          (sel),
    .buy          (buy),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .coin_reject  (coin_reject),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ready (change_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int credit; int busy; int cv; int amt; } snap_t;
  typedef struct { int cyc; int val; } evt_t;

  snap_t q_snap[$];
  evt_t  q_disp[$];
  evt_t  q_rej[$];
  evt_t  q_hs[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Model: credit plus phase 0=taking coins, 1=dispensing, 2=returning money.
  int m_credit = 0;
  int m_phase  = 0;
  int m_idle   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  snap_t s_m;
  evt_t  e_m;
  bit    hit;
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_snap.size() > 0 && q_snap[0].cyc == cyc) begin
        s_m = q_snap.pop_front();
        chk("credit", int'(credit), s_m.credit);
        chk("busy", int'(busy), s_m.busy);
        chk("change_valid", int'(change_valid), s_m.cv);
        chk("change_amt", int'(change_amt), s_m.amt);
      end
      hit = (q_disp.size() > 0 && q_disp[0].cyc == cyc);
      if (dispense || hit) begin
        chk("dispense", int'(dispense), int'(hit));
        if (hit) begin
          e_m = q_disp.pop_front();
          chk("dispense_id", int'(dispense_id), e_m.val);
        end
      end
      hit = (q_rej.size() > 0 && q_rej[0].cyc == cyc);
      if (coin_reject || hit) begin
        chk("coin_reject", int'(coin_reject), int'(hit));
        if (hit) e_m = q_rej.pop_front();
      end
      hit = (q_hs.size() > 0 && q_hs[0].cyc == cyc);
      if ((change_valid && change_ready) || hit) begin
        chk("handshake", int'(change_valid && change_ready), int'(hit));
        if (hit) begin
          e_m = q_hs.pop_front();
          chk("handshake_amt", int'(change_amt), e_m.val);
        end
      end
    end
  end

  // Drive one cycle of inputs and advance the model to predict the next cycle.
  task automatic step(input bit cv_i, input int ct, input bit b, input int s,
                      input bit c, input bit r);
    int    nxt;
    bit    rej;
    int    val;
    evt_t  e;
    snap_t sn;
    nxt = cyc + 1;
    rej = 1'b0;
    val = COIN_TAB[ct];
    coin_valid = cv_i; coin_type = 2'(ct); buy = b; sel = 2'(s);
    cancel = c; change_ready = r;
    case (m_phase)
      0: begin
        if (c && m_credit > 0) begin
          m_phase = 2; rej = cv_i;
        end else if (b && m_credit >= PRICE_TAB[s]) begin
          m_credit = m_credit - PRICE_TAB[s];
          e.cyc = nxt; e.val = s; q_disp.push_back(e);
          m_phase = 1; rej = cv_i;
        end else if (cv_i && m_credit + val <= 255) begin
          m_credit = m_credit + val; m_idle = 0;
        end else begin
          rej = cv_i;
`ifdef VEND_INACT_TIMEOUT_EN
          if (m_credit > 0) begin
            if (m_idle == TMO - 1) m_phase = 2;
            else m_idle++;
          end
`endif
        end
      end
      1: begin
        rej = cv_i;
        m_phase = (m_credit > 0) ? 2 : 0;
      end
      default: begin
        rej = cv_i;
        if (r) begin
          e.cyc = cyc; e.val = m_credit; q_hs.push_back(e);
          m_credit = 0; m_phase = 0;
        end
      end
    endcase
    if (!(m_phase == 0 && m_credit > 0)) m_idle = 0;
    if (rej) begin
      e.cyc = nxt; e.val = 1; q_rej.push_back(e);
    end
    sn.cyc = nxt; sn.credit = m_credit; sn.busy = int'(m_phase != 0);
    sn.cv = int'(m_phase == 2); sn.amt = (m_phase == 2) ? m_credit : 0;
    q_snap.push_back(sn);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0, r);
  endtask

  task automatic coin(input int ct);
    step(1'b1, ct, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear immediately, model and queues restart.
  task automatic do_reset();
    mon_en = 1'b0;
    start_n = 1'b0;
    coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0; change_ready = 1'b0;
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_change_amt", int'(change_amt), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_coin_reject", int'(coin_reject), 0);
    chk("rst_busy", int'(busy), 0);
    q_snap.delete(); q_disp.delete(); q_rej.delete(); q_hs.delete();
    m_credit = 0; m_phase = 0; m_idle = 0;
    @(posedge clk); #1;
    start_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #3;
    do_reset();

    // Exact payment: 30 for product 0, no change.
    coin(1); coin(1); coin(1);
    step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Overpay 50 for product 2, change 30 held until ready.
    coin(2); coin(2);
    step(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(2, 1'b1);

    // Insufficient buy ignored, then cancel refunds 5.
    coin(0);
    step(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Fill to 250, overflow coin rejected, coin during refund rejected.
    for (int i = 0; i < 6; i++) coin(3);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Simultaneous cancel+buy+coin at 30, then reset in the middle of the refund.
    coin(1); coin(1); coin(1);
    step(1'b1, 2, 1'b1, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(2, 1'b1);

`ifdef VEND_INACT_TIMEOUT_EN
    // Idle credit auto-refunds; a later coin restarts the count.
    coin(1);
    idle(14, 1'b0);
    coin(0);
    idle(TMO + 3, 1'b0);
    idle(2, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 40, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 50);
    end

    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    idle(4, 1'b1);
    #5;
    chk("queues_drained", q_snap.size() + q_disp.size() + q_rej.size() + q_hs.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised coin-operated vending controller, successor to the single-price 5/10-coin vending FSM. Accumulates credit from four coin denominations and sells one of N_PROD products with per-product prices. Returns change or a cancel refund as an amount through a valid/ready handshake to the coin-return unit. Sits between the coin acceptor/keypad front end and the dispenser/change-return actuators.

Parameters:
CW, 8, credit and price width in bits; CREDIT_MAX = 2^CW-1.
N_PROD, 4, number of products.
PRICES, {8'd45,8'd20,8'd25,8'd30}, packed N_PROD*CW price vector; product i occupies bits [i*CW +: CW]; default prices: prod0=30, prod1=25, prod2=20, prod3=45.
TIMEOUT_CYC, 1000, inactivity cycles before auto-refund; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge.
start_n  in  1  asynchronous active-low reset.
coin_valid  in  1  one-cycle coin-insert strobe.
coin_type  in  2  denomination code: 0=5, 1=10, 2=25, 3=50.
sel  in  $clog2(N_PROD)  product select; sampled only when buy is accepted.
buy  in  1  purchase request strobe.
cancel  in  1  refund request strobe.
credit  out  CW  current credit (registered).
dispense  out  1  one-cycle dispense pulse.
dispense_id  out  $clog2(N_PROD)  product index; valid while dispense=1.
coin_reject  out  1  one-cycle pulse: coin not accepted, to be returned physically.
change_valid  out  1  change/refund amount valid.
change_amt  out  CW  amount to return.
change_ready  in  1  coin-return unit accepts change_amt.
busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (start_n=0, async): state=IDLE; credit=0; all outputs 0. Reset mid-transaction discards credit and issues no change.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- IDLE/CREDIT, per-cycle event priority: cancel > buy > coin.
  - Coin: if credit+val <= CREDIT_MAX, credit <= credit+val and state -> CREDIT; otherwise coin_reject pulses next cycle and credit is unchanged.
  - A coin arriving in the same cycle as an accepted buy or cancel is rejected (coin_reject).
- buy:
  - Accepted if credit >= PRICES[sel]: credit <= credit-price, dispense_id <= sel, state -> VEND.
  - If credit is insufficient, buy is ignored: no state change, no pulse.
- Dispense timing: dispense is high for exactly the one cycle spent in VEND, i.e. the cycle after buy is sampled. Next state is CHANGE if the remaining credit > 0, else IDLE.
- cancel: with credit > 0 -> CHANGE (full refund). With credit == 0, ignored.
- CHANGE:
  - change_valid=1 and change_amt=credit, held stable until change_ready=1.
  - On the handshake cycle: credit <= 0, next cycle change_valid=0, state -> IDLE.
  - change_ready while change_valid=0 has no effect.
- VEND/CHANGE: busy=1. Any coin is rejected (coin_reject pulse); buy and cancel are ignored.
- Latency: coin to credit update is 1 cycle; buy to dispense is 1 cycle; buy to change_valid is 2 cycles if change is due.
- Arithmetic: unsigned CW-bit; no wrap permitted, guaranteed by the overflow reject; exact payment yields no CHANGE visit.

Optional Feature:
Macro VEND_INACT_TIMEOUT_EN.
- Defined: inactivity counter active in CREDIT. It clears on an accepted coin or on entry to CREDIT. On reaching TIMEOUT_CYC it forces CHANGE with the full credit (auto-refund), with the same handshake as cancel. Counter held at 0 outside CREDIT.
- Undefined: no counter; credit persists indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- Package vend_pkg: state enum (IDLE, CREDIT, VEND, CHANGE); coin_type enum; COIN_VAL constant array {5,10,25,50}; helper function price_of(PRICES, idx).
- One sub-module, vend_inact_timer: counter with clear/enable/expire, instantiated only under VEND_INACT_TIMEOUT_EN.

Test Plan:
1. Coins 10,10,10 then buy sel=0 (price 30) -> credit 30; dispense=1 with dispense_id=0 one cycle after buy; no change_valid; credit=0; IDLE.
2. Coins 25,25 then buy sel=2 (price 20) -> dispense id=2; 2 cycles after buy change_valid=1, change_amt=30; hold change_ready=0 for 5 cycles (amt stable), then ready=1 -> credit=0, IDLE.
3. Coin 5, buy sel=3 (price 45) -> ignored, credit stays 5; then cancel -> change_amt=5; refund completes on handshake.
4. Insert 50 five times (credit 250), then 50 again -> coin_reject pulse, credit stays 250. Coin during CHANGE -> coin_reject.
5. Same cycle cancel+buy+coin with credit 30 -> refund 30 taken, no dispense, coin_reject=1. Assert start_n low during CHANGE -> all outputs 0 immediately, credit=0.
6. (VEND_INACT_TIMEOUT_EN, TIMEOUT_CYC=20) coin 10 then idle -> change_valid with amt 10 exactly 20 cycles after the coin is accepted; a coin at cycle 15 restarts the count.
